// File: rtl/bellek_hakem.sv
// bellek_hakem: two-master arbiter for the single-port system memory.
// Round-robin fairness with a bounded lock for read-modify-write sequences.
module bellek_hakem #(
    parameter int VERI_BIT    = 32,
    parameter int ADRES_BIT   = 32,
    parameter int KILIT_SINIR = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_istek,
    input  logic                 m0_yaz,
    input  logic [ADRES_BIT-1:0] m0_adres,
    input  logic [VERI_BIT-1:0]  m0_yaz_veri,
    input  logic                 m0_kilit,
    output logic                 m0_kabul,
    output logic [VERI_BIT-1:0]  m0_oku_veri,
    input  logic                 m1_istek,
    input  logic                 m1_yaz,
    input  logic [ADRES_BIT-1:0] m1_adres,
    input  logic [VERI_BIT-1:0]  m1_yaz_veri,
    input  logic                 m1_kilit,
    output logic                 m1_kabul,
    output logic [VERI_BIT-1:0]  m1_oku_veri,
    output logic [ADRES_BIT-1:0] bellek_adres,
    output logic [VERI_BIT-1:0]  bellek_yaz_veri,
    output logic                 bellek_yaz,
    input  logic [VERI_BIT-1:0]  bellek_oku_veri
);

    typedef enum logic [1:0] {
        BOSTA,
        ADRES,
        VERI
    } durum_t;

    localparam logic [ADRES_BIT-1:0] ADRES_SIFIR =
        ADRES_BIT'(32'h8000_0000);
    localparam logic [7:0] SINIR = 8'(KILIT_SINIR);

    durum_t               durum;
    logic                 sahip;
    logic                 son_sahip;
    logic                 yaz_r;
    logic                 kilit_bayrak;
    logic                 kilit_kazandi;
    logic [7:0]           kilit_sayac;
    logic [VERI_BIT-1:0]  m0_oku_r;
    logic [VERI_BIT-1:0]  m1_oku_r;

    logic [1:0]           istek;
    logic                 kilit_gecerli;
    logic                 kazanan_var;
    logic                 kazanan;
    logic                 sec_yaz;
    logic [ADRES_BIT-1:0] sec_adres;
    logic [VERI_BIT-1:0]  sec_veri;
    logic                 sahip_kilit;

    // The lock only wins while the owner is still asking for the bus.
    always_comb begin
        istek = {m1_istek, m0_istek};
        kilit_gecerli = kilit_bayrak
                      && istek[son_sahip]
                      && (kilit_sayac < SINIR);
        kazanan_var = |istek;
        if (kilit_gecerli) begin
            kazanan = son_sahip;
        end else if (&istek) begin
            kazanan = ~son_sahip;
        end else begin
            kazanan = istek[1];
        end
    end

    always_comb begin
        sec_yaz     = kazanan ? m1_yaz : m0_yaz;
        sec_adres   = kazanan ? m1_adres : m0_adres;
        sec_veri    = kazanan ? m1_yaz_veri : m0_yaz_veri;
        sahip_kilit = sahip ? m1_kilit : m0_kilit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            durum           <= BOSTA;
            sahip           <= 1'b0;
            yaz_r           <= 1'b0;
            kilit_kazandi   <= 1'b0;
            bellek_adres    <= ADRES_SIFIR;
            bellek_yaz_veri <= '0;
            bellek_yaz      <= 1'b0;
            m0_kabul        <= 1'b0;
            m1_kabul        <= 1'b0;
            m0_oku_r        <= '0;
            m1_oku_r        <= '0;
        end else begin
            m0_kabul        <= 1'b0;
            m1_kabul        <= 1'b0;
            bellek_yaz      <= 1'b0;
            bellek_yaz_veri <= '0;
            unique case (durum)
                BOSTA: begin
                    if (kazanan_var) begin
                        durum         <= ADRES;
                        sahip         <= kazanan;
                        yaz_r         <= sec_yaz;
                        kilit_kazandi <= kilit_gecerli;
                        bellek_adres  <= sec_adres;
                        // A write completes in the address cycle itself.
                        if (sec_yaz) begin
                            bellek_yaz      <= 1'b1;
                            bellek_yaz_veri <= sec_veri;
                            m0_kabul        <= ~kazanan;
                            m1_kabul        <= kazanan;
                        end
                    end
                end
                ADRES: begin
                    if (yaz_r) begin
                        durum <= BOSTA;
                    end else begin
                        durum    <= VERI;
                        m0_kabul <= ~sahip;
                        m1_kabul <= sahip;
                    end
                end
                VERI: begin
                    durum <= BOSTA;
                    if (sahip) begin
                        m1_oku_r <= bellek_oku_veri;
                    end else begin
                        m0_oku_r <= bellek_oku_veri;
                    end
                end
                default: durum <= BOSTA;
            endcase
        end
    end

    // Ownership history advances on the edge that closes a kabul cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            son_sahip    <= 1'b1;
            kilit_bayrak <= 1'b0;
            kilit_sayac  <= 8'd0;
        end else if (m0_kabul || m1_kabul) begin
            son_sahip    <= sahip;
            kilit_bayrak <= sahip_kilit;
            kilit_sayac  <= kilit_kazandi ? kilit_sayac + 8'd1 : 8'd0;
        end
    end

    assign m0_oku_veri = (durum == VERI && !sahip)
                       ? bellek_oku_veri : m0_oku_r;
    assign m1_oku_veri = (durum == VERI && sahip)
                       ? bellek_oku_veri : m1_oku_r;

endmodule

// File: tb/tb_bellek_hakem.sv
// tb_bellek_hakem: scoreboard bench for the two-master memory arbiter.
// Vector table plus hand sequences for fairness, lock and reset cases.
module tb_bellek_hakem;

    logic        clk;
    logic        rst;
    logic        m0_istek, m1_istek;
    logic        m0_yaz, m1_yaz;
    logic [31:0] m0_adres, m1_adres;
    logic [31:0] m0_yaz_veri, m1_yaz_veri;
    logic        m0_kilit, m1_kilit;
    logic        m0_kabul, m1_kabul;
    logic [31:0] m0_oku_veri, m1_oku_veri;
    logic [31:0] bellek_adres;
    logic [31:0] bellek_yaz_veri;
    logic        bellek_yaz;
    logic [31:0] bellek_oku_veri;

    bellek_hakem #(
        .VERI_BIT   (32),
        .ADRES_BIT  (32),
        .KILIT_SINIR(3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_istek       (m0_istek),
        .m0_yaz         (m0_yaz),
        .m0_adres       (m0_adres),
        .m0_yaz_veri    (m0_yaz_veri),
        .m0_kilit       (m0_kilit),
        .m0_kabul       (m0_kabul),
        .m0_oku_veri    (m0_oku_veri),
        .m1_istek       (m1_istek),
        .m1_yaz         (m1_yaz),
        .m1_adres       (m1_adres),
        .m1_yaz_veri    (m1_yaz_veri),
        .m1_kilit       (m1_kilit),
        .m1_kabul       (m1_kabul),
        .m1_oku_veri    (m1_oku_veri),
        .bellek_adres   (bellek_adres),
        .bellek_yaz_veri(bellek_yaz_veri),
        .bellek_yaz     (bellek_yaz),
        .bellek_oku_veri(bellek_oku_veri)
    );

    typedef struct {
        bit          m;
        bit          yaz;
        logic [31:0] adres;
        logic [31:0] veri;
    } beklenti_t;

    typedef struct {
        bit          r0;
        bit          w0;
        logic [31:0] a0;
        logic [31:0] d0;
        bit          r1;
        bit          w1;
        logic [31:0] a1;
        logic [31:0] d1;
        bit          ilk;
    } vek_t;

    beklenti_t   sb[$];
    vek_t        tablo[6];
    int          karsilastirma = 0;
    int          uyusmazlik = 0;
    int          yaz_sayisi = 0;
    logic [31:0] tut0 = '0;
    logic [31:0] tut1 = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] bellek_f(input logic [31:0] a);
        if (a == 32'h8000_0010) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h0F1E_2D3C;
    endfunction

    always @(posedge clk) bellek_oku_veri <= bellek_f(bellek_adres);

    task automatic kontrol(input string ad, input logic [31:0] g,
                           input logic [31:0] b);
        karsilastirma++;
        if (g !== b) begin
            uyusmazlik++;
            $display("FAIL %s: got=%h want=%h", ad, g, b);
        end
    endtask

    // Scoreboard: every kabul pops one expected access and is checked.
    always @(negedge clk) begin
        if (!rst) begin
            tut0 = '0;
            tut1 = '0;
        end else begin
            beklenti_t e;
            if (m0_kabul && m1_kabul)
                kontrol("iki_kabul", 32'd1, 32'd0);
            if (bellek_yaz && !(m0_kabul || m1_kabul))
                kontrol("kabulsuz_yaz", 32'd1, 32'd0);
            if (bellek_yaz) yaz_sayisi++;
            for (int m = 0; m < 2; m++) begin
                logic        kab;
                logic [31:0] oku;
                kab = (m == 1) ? m1_kabul : m0_kabul;
                oku = (m == 1) ? m1_oku_veri : m0_oku_veri;
                if (kab) begin
                    if (sb.size() == 0) begin
                        kontrol("beklenmeyen_kabul", 32'(m), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        kontrol("sahip", 32'(m), 32'(e.m));
                        kontrol("adres", bellek_adres, e.adres);
                        kontrol("yaz_strobe", 32'(bellek_yaz), 32'(e.yaz));
                        if (e.yaz) begin
                            kontrol("yaz_veri", bellek_yaz_veri, e.veri);
                        end else begin
                            kontrol("oku_veri", oku, e.veri);
                            if (m == 1) tut1 = e.veri;
                            else tut0 = e.veri;
                        end
                    end
                end else begin
                    kontrol("oku_tut", oku, (m == 1) ? tut1 : tut0);
                end
            end
        end
    end

    task automatic sur(input bit m, input bit istek, input bit yaz,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit k);
        if (m) begin
            m1_istek = istek; m1_yaz = yaz; m1_adres = a;
            m1_yaz_veri = d; m1_kilit = k;
        end else begin
            m0_istek = istek; m0_yaz = yaz; m0_adres = a;
            m0_yaz_veri = d; m0_kilit = k;
        end
    endtask

    task automatic tek(input bit m, input bit yaz, input logic [31:0] a,
                       input logic [31:0] d);
        int n;
        bit goruldu;
        sb.push_back('{m, yaz, a, yaz ? d : bellek_f(a)});
        sur(m, 1'b1, yaz, a, d, 1'b0);
        n = 0;
        goruldu = 0;
        while (!goruldu && n < 20) begin
            @(negedge clk);
            n++;
            if (m ? m1_kabul : m0_kabul) goruldu = 1;
        end
        sur(m, 1'b0, 1'b0, a, d, 1'b0);
        kontrol("gecikme", 32'(n), yaz ? 32'd1 : 32'd2);
        repeat (2) @(negedge clk);
    endtask

    task automatic cift(input vek_t v);
        bit b0, b1;
        int n;
        beklenti_t e0, e1;
        e0 = '{1'b0, v.w0, v.a0, v.w0 ? v.d0 : bellek_f(v.a0)};
        e1 = '{1'b1, v.w1, v.a1, v.w1 ? v.d1 : bellek_f(v.a1)};
        if (v.r0 && v.r1) begin
            if (v.ilk) begin sb.push_back(e1); sb.push_back(e0); end
            else begin sb.push_back(e0); sb.push_back(e1); end
        end else if (v.r0) sb.push_back(e0);
        else if (v.r1) sb.push_back(e1);
        sur(1'b0, v.r0, v.w0, v.a0, v.d0, 1'b0);
        sur(1'b1, v.r1, v.w1, v.a1, v.d1, 1'b0);
        b0 = !v.r0;
        b1 = !v.r1;
        n = 0;
        while (!(b0 && b1) && n < 40) begin
            @(negedge clk);
            n++;
            if (m0_kabul) begin b0 = 1; m0_istek = 1'b0; end
            if (m1_kabul) begin b1 = 1; m1_istek = 1'b0; end
        end
        m0_istek = 1'b0;
        m1_istek = 1'b0;
        kontrol("tablo_bitti", {30'd0, b1, b0}, 32'd3);
        repeat (2) @(negedge clk);
    endtask

    // Both masters keep reading; sira bit i names the master of grant i.
    task automatic calistir(input int toplam, input int m0_sinir,
                            input logic [15:0] sira, input bit k0);
        int c0, c1, say0, say1, top, n;
        c0 = 0; c1 = 0;
        for (int i = 0; i < toplam; i++) begin
            logic [31:0] a;
            if (sira[i]) begin
                a = 32'h8000_0300 + 32'(4 * c1); c1++;
            end else begin
                a = 32'h8000_0200 + 32'(4 * c0); c0++;
            end
            sb.push_back('{sira[i], 1'b0, a, bellek_f(a)});
        end
        sur(1'b0, 1'b1, 1'b0, 32'h8000_0200, '0, k0);
        sur(1'b1, 1'b1, 1'b0, 32'h8000_0300, '0, 1'b0);
        say0 = 0; say1 = 0; top = 0; n = 0;
        while (top < toplam && n < 200) begin
            @(negedge clk);
            n++;
            if (m0_kabul) begin
                say0++; top++;
                m0_adres = 32'h8000_0200 + 32'(4 * say0);
                if (say0 >= m0_sinir) m0_istek = 1'b0;
            end
            if (m1_kabul) begin
                say1++; top++;
                m1_adres = 32'h8000_0300 + 32'(4 * say1);
            end
        end
        m0_istek = 1'b0;
        m1_istek = 1'b0;
        m0_kilit = 1'b0;
        kontrol("sira_sayisi", 32'(top), 32'(toplam));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int y0;
        tablo[0] = '{1, 0, 32'h8000_0020, 0, 1, 0, 32'h8000_0030, 0, 0};
        tablo[1] = '{1, 0, 32'h8000_0050, 0, 0, 0, 32'h0, 0, 0};
        tablo[2] = '{1, 0, 32'h8000_0060, 0,
                     1, 1, 32'h8000_0108, 32'h0BAD_F00D, 1};
        tablo[3] = '{1, 1, 32'h8000_010C, 32'h1111_2222,
                     1, 1, 32'h8000_0110, 32'h3333_4444, 1};
        tablo[4] = '{0, 0, 32'h0, 0, 1, 0, 32'h8000_0070, 0, 0};
        tablo[5] = '{1, 0, 32'h8000_0080, 0, 1, 0, 32'h8000_0090, 0, 0};

        rst = 1'b1;
        sur(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        sur(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        kontrol("rst_adres", bellek_adres, 32'h8000_0000);
        kontrol("rst_yaz", 32'(bellek_yaz), 32'd0);
        kontrol("rst_yaz_veri", bellek_yaz_veri, 32'd0);
        kontrol("rst_kabul", {30'd0, m1_kabul, m0_kabul}, 32'd0);
        kontrol("rst_oku0", m0_oku_veri, 32'd0);
        kontrol("rst_oku1", m1_oku_veri, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        kontrol("bos_adres", bellek_adres, 32'h8000_0000);

        tek(1'b0, 1'b0, 32'h8000_0010, '0);
        kontrol("oku_deadbeef", m0_oku_veri, 32'hDEAD_BEEF);

        y0 = yaz_sayisi;
        tek(1'b1, 1'b1, 32'h8000_0100, 32'h1234_5678);
        kontrol("yaz_darbe", 32'(yaz_sayisi - y0), 32'd1);

        for (int i = 0; i < 6; i++) cift(tablo[i]);

        calistir(6, 99, 16'h002A, 1'b0);
        calistir(4, 3, 16'h0008, 1'b1);
        kontrol("kilit_sayac", 32'(dut.kilit_sayac), 32'd0);
        calistir(5, 99, 16'h0010, 1'b1);

        sur(1'b1, 1'b1, 1'b1, 32'h8000_0180, 32'hA5A5_5A5A, 1'b0);
        @(posedge clk);
        #2;
        kontrol("adres_yaz", 32'(bellek_yaz), 32'd1);
        rst = 1'b0;
        #1;
        kontrol("rst_yaz_dus", 32'(bellek_yaz), 32'd0);
        kontrol("rst_kabul_yok", {30'd0, m1_kabul, m0_kabul}, 32'd0);
        sur(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        kontrol("rst2_adres", bellek_adres, 32'h8000_0000);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            kontrol("rst2_bos", {30'd0, m1_kabul, m0_kabul}, 32'd0);
        end
        calistir(2, 99, 16'h0002, 1'b0);
        tek(1'b0, 1'b0, 32'h8000_0400, '0);

        kontrol("sb_bos", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 karsilastirma, uyusmazlik);
        $finish;
    end

endmodule
